// File: rtl/sass_voice_pkg.sv
// sass_voice_pkg: shared types and limits for the voice scheduler.
package sass_voice_pkg;
  localparam int MAX_VOICES = 8;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, DONE} sched_state_t;
  typedef logic [7:0] sample_t;
endpackage

// File: rtl/next_voice_finder.sv
// next_voice_finder: lowest enabled voice index above cur, or from index 0 when first is set.
module next_voice_finder #(
  parameter int NUM_VOICES = 4,
  localparam int VW = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0] en,
  input  logic [VW-1:0]         cur,
  input  logic                  first,
  output logic [VW-1:0]         nxt,
  output logic                  valid
);
  always_comb begin
    nxt = '0;
    valid = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--)
      if (en[i] && (first || i > int'(cur))) begin
        nxt = VW'(i);
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: time-multiplexes one shared divider across voices each sample frame.
// Define VOICE_SCHED_TIMEOUT_EN to add a per-divide watchdog of TIMEOUT_CYC cycles.
module voice_scheduler
  import sass_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int TIMEOUT_CYC = 64,
  localparam int VW = $clog2(NUM_VOICES)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    sample_now,
  input  logic [NUM_VOICES-1:0]   voice_en,
  input  logic                    clr_overrun,
  output logic                    div_start,
  output logic [VW-1:0]           div_voice,
  input  logic                    div_done,
  input  logic [7:0]              div_q,
  output logic [8*NUM_VOICES-1:0] voice_samples,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overrun
);
  sched_state_t state, state_nxt;
  logic [NUM_VOICES-1:0] en_q;
  logic [VW-1:0] cur, nxt;
  logic nxt_valid, timeout;
  sample_t q_r;

`ifdef VOICE_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) cnt <= '0;
    else cnt <= (state == WAIT) ? cnt + CW'(1) : '0;
  assign timeout = (state == WAIT) && !div_done && (cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  // In IDLE the finder looks at the live enables to pick the first voice of the new frame.
  next_voice_finder #(.NUM_VOICES(NUM_VOICES)) u_find (
    .en(state == IDLE ? voice_en : en_q),
    .cur(cur),
    .first(state == IDLE),
    .nxt(nxt),
    .valid(nxt_valid)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_now) state_nxt = nxt_valid ? ISSUE : DONE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (div_done || timeout) state_nxt = STORE;
      STORE:   state_nxt = nxt_valid ? ISSUE : DONE;
      default: state_nxt = IDLE;
    endcase
    div_start = state == ISSUE;
    frame_done = state == DONE;
    busy = state != IDLE;
    div_voice = cur;
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      en_q <= '0;
      cur <= '0;
      q_r <= '0;
      voice_samples <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((busy && sample_now) || timeout) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
      if (state == IDLE && sample_now) begin
        en_q <= voice_en;
        cur <= nxt;
        for (int i = 0; i < NUM_VOICES; i++)
          if (!voice_en[i]) voice_samples[8*i +: 8] <= '0;
      end
      if (state == WAIT) q_r <= div_done ? div_q : '0;
      if (state == STORE) begin
        voice_samples[8*int'(cur) +: 8] <= q_r;
        if (nxt_valid) cur <= nxt;
      end
    end
endmodule
